// File: rtl/canvas_arbiter.sv
// Single-port canvas RAM arbiter: recognizer read > clear sweep > pen draw.
// Define CANVAS_ARB_STATS_EN to add the saturating draw_stall_cnt output.
module canvas_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data,
    input  logic              draw_req,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic              draw_data,
    output logic              draw_grant,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [1:0]        owner,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_wdata,
    input  logic              mem_rdata
`ifdef CANVAS_ARB_STATS_EN
    ,
    output logic [15:0]       draw_stall_cnt
`endif
);

    typedef enum logic [1:0] {C_IDLE, C_PEND, C_RUN} clr_state_e;
    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_READ  = 2'd1,
        OWN_CLEAR = 2'd2,
        OWN_DRAW  = 2'd3
    } owner_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              done_q, done_d;
    owner_e            own;

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= C_IDLE;
            clr_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            done_q    <= done_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        done_d    = 1'b0;
        unique case (state_q)
            C_IDLE: if (clear_req) state_d = C_PEND;
            C_PEND: begin
                if (!rd_en) begin
                    state_d   = C_RUN;
                    clr_cnt_d = '0;
                end
            end
            C_RUN: begin
                // A read cycle simply holds the sweep position.
                if (!rd_en) begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d   = C_IDLE;
                        clr_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        own        = OWN_IDLE;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = 1'b0;
        draw_grant = 1'b0;
        if (!rst) begin
            own = OWN_IDLE;
        end else if (rd_en) begin
            own      = OWN_READ;
            mem_addr = rd_addr;
        end else if (state_q == C_RUN) begin
            own      = OWN_CLEAR;
            mem_addr = clr_cnt_q;
            mem_we   = 1'b1;
        end else if (draw_req) begin
            own        = OWN_DRAW;
            mem_addr   = draw_addr;
            mem_we     = 1'b1;
            mem_wdata  = draw_data;
            draw_grant = 1'b1;
        end
    end

    assign owner      = own;
    assign rd_data    = mem_rdata;
    assign clear_busy = rst && (state_q != C_IDLE);
    assign clear_done = rst && done_q;

`ifdef CANVAS_ARB_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (draw_req && !draw_grant && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) stall_q <= '0;
        else      stall_q <= stall_d;
    end

    assign draw_stall_cnt = rst ? stall_q : 16'd0;
`endif

endmodule

// File: tb/tb_canvas_arbiter.sv
// Self-checking bench for canvas_arbiter: behavioural model plus directed scenarios and random traffic.
// Build with CANVAS_ARB_STATS_EN defined to also check draw_stall_cnt.
module tb_canvas_arbiter;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data;
    logic              draw_req;
    logic [ADDR_W-1:0] draw_addr;
    logic              draw_data;
    logic              draw_grant;
    logic              clear_req;
    logic              clear_busy;
    logic              clear_done;
    logic [1:0]        owner;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_wdata;
    logic              mem_rdata;
`ifdef CANVAS_ARB_STATS_EN
    logic [15:0]       draw_stall_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    bit canvas [DEPTH];

    // Behavioural model: clear pending flag, writes remaining in the sweep, done flag, stall count.
    bit m_pend = 1'b0;
    int m_left = 0;
    bit m_done = 1'b0;
    int m_stall = 0;

    // Event monitors used by the directed scenarios.
    int clr_writes = 0;
    int first_clr_addr = -1;
    int done_cnt = 0;
    int done_cyc = -1;
    int grant_cnt = 0;
    int req_cyc = 0;

    always #5 clk = ~clk;

    canvas_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .draw_req       (draw_req),
        .draw_addr      (draw_addr),
        .draw_data      (draw_data),
        .draw_grant     (draw_grant),
        .clear_req      (clear_req),
        .clear_busy     (clear_busy),
        .clear_done     (clear_done),
        .owner          (owner),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
`ifdef CANVAS_ARB_STATS_EN
        ,
        .draw_stall_cnt (draw_stall_cnt)
`endif
    );

    assign mem_rdata = canvas[mem_addr];

    always @(posedge clk) begin
        if (mem_we) canvas[mem_addr] = mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model advance on each rising edge.
    always @(posedge clk) begin
        bit exp_grant;
        cyc++;
        if (!rst) begin
            m_pend  = 1'b0;
            m_left  = 0;
            m_done  = 1'b0;
            m_stall = 0;
        end else begin
            exp_grant = !rd_en && (m_left == 0) && draw_req;
            if (draw_req && !exp_grant && m_stall < 65535) m_stall++;
            m_done = 1'b0;
            if (m_left > 0) begin
                if (!rd_en) begin
                    m_left--;
                    if (m_left == 0) m_done = 1'b1;
                end
            end else if (m_pend) begin
                if (!rd_en) begin
                    m_pend = 1'b0;
                    m_left = DEPTH;
                end
            end else if (clear_req) begin
                m_pend = 1'b1;
            end
        end
    end

    // Compare DUT outputs with the model mid-cycle.
    always @(negedge clk) begin
        logic [1:0]        e_own;
        logic [ADDR_W-1:0] e_addr;
        logic              e_we, e_wd, e_gr;
        e_own = 2'd0; e_addr = '0; e_we = 1'b0; e_wd = 1'b0; e_gr = 1'b0;
        if (rst) begin
            if (rd_en) begin
                e_own = 2'd1; e_addr = rd_addr;
            end else if (m_left > 0) begin
                e_own = 2'd2; e_addr = ADDR_W'(DEPTH - m_left); e_we = 1'b1;
            end else if (draw_req) begin
                e_own = 2'd3; e_addr = draw_addr; e_we = 1'b1; e_wd = draw_data; e_gr = 1'b1;
            end
        end
        check("owner", owner, e_own);
        check("mem_addr", mem_addr, e_addr);
        check("mem_we", mem_we, e_we);
        if (e_we) check("mem_wdata", mem_wdata, e_wd);
        check("draw_grant", draw_grant, e_gr);
        check("rd_data", rd_data, canvas[e_addr]);
        check("clear_busy", clear_busy, rst && (m_pend || m_left > 0));
        check("clear_done", clear_done, rst && m_done);
`ifdef CANVAS_ARB_STATS_EN
        check("draw_stall_cnt", draw_stall_cnt, rst ? m_stall : 0);
`endif
        if (mem_we && owner == 2'd2) begin
            if (clr_writes == 0) first_clr_addr = int'(mem_addr);
            clr_writes++;
        end
        if (clear_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (draw_grant) grant_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        rd_en = 1'b0; rd_addr = '0; draw_req = 1'b0; draw_addr = '0;
        draw_data = 1'b0; clear_req = 1'b0;
    endtask

    task automatic clear_monitors();
        clr_writes = 0; first_clr_addr = -1; done_cnt = 0; done_cyc = -1; grant_cnt = 0;
    endtask

    task automatic start_clear();
        step();
        clear_req = 1'b1;
        req_cyc = cyc;
        step();
        clear_req = 1'b0;
    endtask

    // Stops in the cycle where the sweep writes address a.
    task automatic wait_clr_addr(input int a);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(mem_we && owner == 2'd2 && int'(mem_addr) == a) && n < 3000);
        if (n >= 3000) check("wait_clr_addr_timeout", n, 0);
    endtask

    task automatic wait_clear_end();
        int n = 0;
        do begin
            step();
            n++;
        end while (clear_busy && n < 4000);
        if (n >= 4000) check("wait_clear_end_timeout", n, 0);
        settle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ones;
        rst = 1'b0;
        quiet_inputs();

        // Reset dominates every requester.
        rd_en = 1'b1; draw_req = 1'b1; clear_req = 1'b1; rd_addr = 10'h3FF;
        step(); step();
        settle();
        check("rst_owner", owner, 2'd0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_grant", draw_grant, 1'b0);
        check("rst_busy", clear_busy, 1'b0);
        check("rst_mem_addr", mem_addr, 10'h000);
        step();
        rst = 1'b1;
        quiet_inputs();

        // Draw while idle is granted in the same cycle.
        step();
        draw_req = 1'b1; draw_addr = 10'h155; draw_data = 1'b1;
        settle();
        check("idle_draw_grant", draw_grant, 1'b1);
        check("idle_draw_we", mem_we, 1'b1);
        check("idle_draw_addr", mem_addr, 10'h155);
        check("idle_draw_owner", owner, 2'd3);
        step();
        draw_req = 1'b0;
        settle();
        check("idle_draw_written", canvas[10'h155], 1'b1);

        // Read burst blocks a held draw for all 1024 cycles.
        step(); rst = 1'b0;
        step(); rst = 1'b1;
        clear_monitors();
        for (int i = 0; i < DEPTH; i++) begin
            step();
            rd_en = 1'b1; rd_addr = ADDR_W'(i);
            draw_req = 1'b1; draw_addr = 10'h02A; draw_data = 1'b1;
        end
        settle();
        check("burst_no_grants", grant_cnt, 0);
        step();
        rd_en = 1'b0;
        settle();
        check("burst_release_grant", draw_grant, 1'b1);
        check("burst_release_owner", owner, 2'd3);
`ifdef CANVAS_ARB_STATS_EN
        check("burst_stall_cnt", draw_stall_cnt, 16'd1024);
`endif
        step();
        quiet_inputs();

        // Clear alone sweeps a full canvas of ones to zero.
        for (int i = 0; i < DEPTH; i++) canvas[i] = 1'b1;
        clear_monitors();
        start_clear();
        wait_clear_end();
        ones = 0;
        for (int i = 0; i < DEPTH; i++) ones += int'(canvas[i]);
        check("clear_writes", clr_writes, 1024);
        check("clear_first_addr", first_clr_addr, 0);
        check("clear_done_count", done_cnt, 1);
        check("clear_done_delay", done_cyc - req_cyc, 1026);
        check("clear_ones_left", ones, 0);
        check("clear_busy_after", clear_busy, 1'b0);

        // Read of 10 cycles starting at sweep position 500.
        clear_monitors();
        start_clear();
        wait_clr_addr(499);
        for (int i = 0; i < 10; i++) begin
            step();
            rd_en = 1'b1; rd_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        end
        step();
        rd_en = 1'b0;
        settle();
        check("resume_addr", mem_addr, 10'd500);
        check("resume_we", mem_we, 1'b1);
        wait_clear_end();
        check("paused_writes", clr_writes, 1024);
        check("paused_done_delay", done_cyc - req_cyc, 1036);

        // Reset at sweep position 300 aborts without clear_done.
        clear_monitors();
        start_clear();
        wait_clr_addr(299);
        step();
        rst = 1'b0;
        settle();
        check("abort_mem_we", mem_we, 1'b0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 40; i++) step();
        settle();
        check("abort_no_done", done_cnt, 0);
        check("abort_not_busy", clear_busy, 1'b0);
        clear_monitors();
        start_clear();
        wait_clear_end();
        check("restart_first_addr", first_clr_addr, 0);
        check("restart_writes", clr_writes, 1024);

        // Duplicate request at sweep position 100 is ignored.
        clear_monitors();
        start_clear();
        wait_clr_addr(99);
        step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        wait_clear_end();
        check("dup_writes", clr_writes, 1024);
        check("dup_done_count", done_cnt, 1);
        check("dup_done_delay", done_cyc - req_cyc, 1026);

        // Random traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            step();
            if ($urandom_range(0, 19) == 0) rd_en = ~rd_en;
            rd_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
            draw_req  = 1'($urandom_range(0, 1));
            draw_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            draw_data = 1'($urandom_range(0, 1));
            clear_req = ($urandom_range(0, 99) < 3);
            rst       = ($urandom_range(0, 999) != 0);
        end
        step();
        rst = 1'b1;
        quiet_inputs();
        step();
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/canvas_arbiter.md
# canvas_arbiter

Single-port access controller for the 32x32 drawing canvas RAM, shared by the pen/draw writer, the recognizer's sequential reader, and a built-in clear sweeper. It sits between those requesters and the canvas memory. It guarantees the recognizer an uninterrupted 1024-cycle read burst, because the recognizer cannot stall. It also serialises pen writes and full-canvas clears around that burst.

## Interface
- `ADDR_W`, 10, canvas address width
- `DEPTH`, 1024, canvas cells; the clear sweep covers 0..DEPTH-1
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `rd_en`  in  1  recognizer read enable; level, held for the whole burst
- `rd_addr`  in  ADDR_W  recognizer read address
- `rd_data`  out  1  canvas read data to the recognizer; equals `mem_rdata`
- `draw_req`  in  1  pen write request; held until granted
- `draw_addr`  in  ADDR_W  pen write address
- `draw_data`  in  1  pen pixel value
- `draw_grant`  out  1  pen write performed this cycle
- `clear_req`  in  1  one-cycle pulse requesting a full-canvas clear
- `clear_busy`  out  1  clear pending or in progress
- `clear_done`  out  1  one-cycle pulse after the last clear write
- `owner`  out  2  current port owner: 0 idle, 1 read, 2 clear, 3 draw
- `mem_addr`  out  ADDR_W  canvas RAM address
- `mem_we`  out  1  canvas RAM write enable
- `mem_wdata`  out  1  canvas RAM write data
- `mem_rdata`  in  1  canvas RAM read data
- `draw_stall_cnt`  out  16  saturating count of denied draw cycles; present only with `CANVAS_ARB_STATS_EN`

## Operation
- Port ownership is resolved combinationally every cycle, with fixed priority: read > clear > draw.
- **Read.** While `rd_en`=1, the port is owned by the recognizer regardless of other state.
  - Drives `mem_addr`=`rd_addr`, `mem_we`=0, `owner`=1.
  - `draw_grant`=0 throughout.
- **Clear FSM** states: C_IDLE, C_PEND, C_RUN.
  - C_IDLE: on `clear_req`, go to C_PEND.
  - C_PEND: when `rd_en`=0, go to C_RUN with `clr_cnt`=0.
  - C_RUN: in each cycle with `rd_en`=0, drive `mem_addr`=`clr_cnt`, `mem_we`=1, `mem_wdata`=0, `owner`=2, then increment `clr_cnt`.
  - C_RUN, `rd_en`=1: `clr_cnt` holds, so the sweep pauses. The recognizer reads partially cleared data; this is accepted.
  - C_RUN, after the write at `clr_cnt`=DEPTH-1: return to C_IDLE and pulse `clear_done` on the next cycle.
  - `clear_busy`=1 in C_PEND and C_RUN.
  - `clear_req` while already C_PEND or C_RUN is ignored; no queueing.
- **Draw.** When there is no read and the clear FSM is not in C_RUN, `draw_req`=1 gives:
  - `draw_grant`=1, `mem_addr`=`draw_addr`, `mem_we`=1, `mem_wdata`=`draw_data`, `owner`=3.
  - Draw is allowed during C_PEND only in cycles where `rd_en`=0. In practice the pending clear starts that same edge, so draw is blocked from the next cycle on.
- **Idle** (no owner): `mem_addr`=0, `mem_we`=0, `owner`=0.

## Timing
- `mem_*`, `draw_grant` and `owner` are combinational from current state and inputs, so a grant and its write happen in the same cycle.
- `rd_data` is a pass-through of `mem_rdata`; RAM read latency is whatever the RAM provides. No added delay.
- Clear with no read interference takes exactly DEPTH cycles of `mem_we`=1 from the cycle after `clear_req`. `clear_done` follows in the next cycle, and `clear_busy` falls in that same cycle.
- A `clear_req` arriving during a read burst starts its sweep on the first cycle with `rd_en`=0.
- A simultaneous `clear_req` and `draw_req` in idle: draw is granted that cycle (the FSM is not yet in C_RUN). The clear starts next cycle.
- Reset (`rst`=0 at an edge):
  - Clear FSM goes to C_IDLE, `clr_cnt`=0; a clear in progress is aborted with no `clear_done`.
  - While `rst`=0: `mem_we`=0, `draw_grant`=0, `clear_busy`=0, `clear_done`=0, `owner`=0, `mem_addr`=0, `draw_stall_cnt`=0.

## Configuration
- `CANVAS_ARB_STATS_EN` defined:
  - Adds the `draw_stall_cnt` port and a 16-bit register.
  - The counter increments in every cycle with `draw_req`=1 and `draw_grant`=0, saturates at 0xFFFF, and resets to 0.
- Not defined: the port and register are absent; all other behaviour is identical.

## Test plan
- Draw while idle: `draw_req`=1, `draw_addr`=0x155, `draw_data`=1 → same cycle `draw_grant`=1, `mem_we`=1, `mem_addr`=0x155, `owner`=3.
- Read burst blocks draw: `rd_en` high for 1024 cycles, `rd_addr` sweeping 0..1023, `draw_req` held → `draw_grant`=0 for all 1024 cycles; granted the first cycle after `rd_en` falls. With stats enabled, `draw_stall_cnt`=1024.
- Clear alone: `clear_req` pulse → 1024 consecutive writes of 0 to addresses 0..1023, then `clear_done` for 1 cycle, then `clear_busy`=0.
- Read during clear: `rd_en` high for 10 cycles starting at `clr_cnt`=500 → no writes during those 10 cycles; the sweep resumes at 500; `clear_done` is delayed by exactly 10 cycles.
- Reset mid-clear: `rst`=0 at `clr_cnt`=300 → `mem_we`=0 next cycle; no `clear_done`; a later `clear_req` restarts at address 0.
- Duplicate `clear_req` at `clr_cnt`=100 → ignored; total of exactly 1024 writes and one `clear_done`.
